// File: rtl/spd_req_if.sv
// spd_req_if: host/transceiver-side signal bundle for spd_req_ctrl.
//   master : the speed-change controller (drives reconfig_req/speed, status)
//   slave  : host register + reconfiguration controller + CDR
// Signals:
//   cfg_linkspeed      host-requested speed (0 = none, 1..4 legal)
//   reconfig_req/speed request + target speed to reconfiguration controller
//   reconfig_ack/busy  single-cycle ack and in-progress flag back
//   rx_is_lockedtodata asynchronous CDR lock
//   req_LE_LINKSPEED   speed being / already applied
//   stat_LE_LINKSPEED  speed achieved (0 while in flight or after failure)
//   spd_chg_busy/err   controller busy, sticky error
interface spd_req_if;
  logic [3:0] cfg_linkspeed;
  logic       reconfig_req;
  logic [3:0] reconfig_speed;
  logic       reconfig_ack;
  logic       reconfig_busy;
  logic       rx_is_lockedtodata;
  logic [3:0] req_LE_LINKSPEED;
  logic [3:0] stat_LE_LINKSPEED;
  logic       spd_chg_busy;
  logic       spd_chg_err;

  modport master (
    input  cfg_linkspeed, reconfig_ack, reconfig_busy, rx_is_lockedtodata,
    output reconfig_req, reconfig_speed, req_LE_LINKSPEED, stat_LE_LINKSPEED,
           spd_chg_busy, spd_chg_err
  );

  modport slave (
    output cfg_linkspeed, reconfig_ack, reconfig_busy, rx_is_lockedtodata,
    input  reconfig_req, reconfig_speed, req_LE_LINKSPEED, stat_LE_LINKSPEED,
           spd_chg_busy, spd_chg_err
  );
endinterface

// File: rtl/spd_req_ctrl.sv
// spd_req_ctrl: initiating side of the link-speed change protocol.
// Takes a host speed request, drives the transceiver reconfiguration
// controller through req/ack/busy, waits for CDR lock at the new rate and
// publishes the requested/achieved speed to the downstream link monitor.
//
// Ports:
//   clk  single clock
//   rst  asynchronous active-high reset
//   bus  spd_req_if.master (see rtl/spd_req_if.sv for the signal list)
//
// Parameters:
//   TMO_W     timeout counter width (timeout after 2^TMO_W cycles in a state)
//   MAX_RETRY reconfiguration retries after a lock timeout
//   SIM_ONLY  1 shortens every timeout to 2^8 cycles
//
// Build option:
//   SPD_REQ_RETRY_EN  defined: lock timeout goes through RETRY (up to
//                     MAX_RETRY extra attempts); undefined: lock timeout fails
//                     immediately and no retry counter exists.
module spd_req_ctrl #(
  parameter int TMO_W     = 24,
  parameter int MAX_RETRY = 3,
  parameter bit SIM_ONLY  = 1'b0
) (
  input logic       clk,
  input logic       rst,
  spd_req_if.master bus
);
  localparam int TW = SIM_ONLY ? 8 : TMO_W;

  if (TMO_W < 8 || MAX_RETRY < 0) begin : g_param_chk
    $error("spd_req_ctrl: TMO_W must be >= 8 and MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {IDLE, REQ, WAIT_DONE, WAIT_LOCK, RETRY} state_t;

  state_t        state;
  logic [3:0]    cfg_q, cur_spd, tgt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    lock_sync;
  logic          tmo, cfg_legal, cfg_bad, fail_now;

`ifdef SPD_REQ_RETRY_EN
  localparam int RC_W = $clog2(MAX_RETRY + 2);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);
  logic [RC_W-1:0] retry_cnt;
`endif

  // Counter saturates at all-ones, which is also the timeout condition.
  assign tmo       = &tmo_cnt;
  assign cfg_legal = cfg_q inside {[4'h1:4'h4]};
  assign cfg_bad   = cfg_q >= 4'h5;

  // Conditions that abandon the current target (err, cur_spd=0, back to IDLE).
  always_comb begin
    fail_now = 1'b0;
    case (state)
      REQ:       fail_now = !bus.reconfig_ack && tmo;
      WAIT_DONE: fail_now = bus.reconfig_busy && tmo;
`ifdef SPD_REQ_RETRY_EN
      RETRY:     fail_now = retry_cnt >= RC_MAX;
`else
      WAIT_LOCK: fail_now = !lock_sync[1] && tmo;
`endif
      default:   fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cfg_q                 <= '0;
      cur_spd               <= '0;
      tgt                   <= '0;
      tmo_cnt               <= '0;
      lock_sync             <= '0;
`ifdef SPD_REQ_RETRY_EN
      retry_cnt             <= '0;
`endif
      bus.reconfig_req      <= 1'b0;
      bus.reconfig_speed    <= '0;
      bus.req_LE_LINKSPEED  <= '0;
      bus.stat_LE_LINKSPEED <= '0;
      bus.spd_chg_busy      <= 1'b0;
      bus.spd_chg_err       <= 1'b0;
    end else begin
      cfg_q     <= bus.cfg_linkspeed;
      lock_sync <= {lock_sync[0], bus.rx_is_lockedtodata};
      if (!tmo && (state == REQ || state == WAIT_DONE || state == WAIT_LOCK))
        tmo_cnt <= tmo_cnt + 1'b1;

      if (fail_now) begin
        bus.spd_chg_err       <= 1'b1;
        bus.reconfig_req      <= 1'b0;
        bus.stat_LE_LINKSPEED <= '0;
        bus.spd_chg_busy      <= 1'b0;
        cur_spd               <= '0;
        state                 <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // cfg_q == cur_spd (including 0 == 0) is the idle steady state.
            if (cfg_q != cur_spd) begin
              if (cfg_legal) begin
                tgt                   <= cfg_q;
                bus.reconfig_req      <= 1'b1;
                bus.reconfig_speed    <= cfg_q;
                bus.req_LE_LINKSPEED  <= cfg_q;
                bus.stat_LE_LINKSPEED <= '0;
                bus.spd_chg_busy      <= 1'b1;
                bus.spd_chg_err       <= 1'b0;
                tmo_cnt               <= '0;
`ifdef SPD_REQ_RETRY_EN
                retry_cnt             <= '0;
`endif
                state                 <= REQ;
              end else if (cfg_bad) begin
                bus.spd_chg_err <= 1'b1;
              end
            end
          end
          REQ: begin
            if (bus.reconfig_ack) begin
              bus.reconfig_req <= 1'b0;
              tmo_cnt          <= '0;
              state            <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (!bus.reconfig_busy) begin
              tmo_cnt <= '0;
              state   <= WAIT_LOCK;
            end
          end
          WAIT_LOCK: begin
            if (lock_sync[1]) begin
              cur_spd               <= tgt;
              bus.stat_LE_LINKSPEED <= tgt;
              bus.spd_chg_busy      <= 1'b0;
              state                 <= IDLE;
            end
`ifdef SPD_REQ_RETRY_EN
            else if (tmo) begin
              tmo_cnt <= '0;
              state   <= RETRY;
            end
`endif
          end
`ifdef SPD_REQ_RETRY_EN
          RETRY: begin
            // Only reached with retries left; exhaustion is handled by fail_now.
            retry_cnt        <= retry_cnt + 1'b1;
            bus.reconfig_req <= 1'b1;
            tmo_cnt          <= '0;
            state            <= REQ;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spd_req_ctrl.sv
module tb_spd_req_ctrl;
  logic clk, rst;
  spd_req_if bus();

  spd_req_ctrl #(.TMO_W(24), .MAX_RETRY(3), .SIM_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reconfiguration controller / CDR environment knobs (main process writes).
  bit ack_en = 1'b1, lock_en = 1'b1;
  int ack_dly = 2, busy_len = 4;
  logic rcfg_active;

  // Expected-state model: what the host should observe after each request.
  logic [3:0] m_cur = 4'h0, m_stat = 4'h0, m_req_le = 4'h0;
  logic       m_err = 1'b0;

`ifdef SPD_REQ_RETRY_EN
  localparam int EXP_ATTEMPTS = 4;
`else
  localparam int EXP_ATTEMPTS = 1;
`endif

  // Lock is lost while the transceiver is being reconfigured.
  assign bus.rx_is_lockedtodata = lock_en & ~rcfg_active;

  // Responder: ack after ack_dly cycles, busy for busy_len cycles.
  initial begin
    bus.reconfig_ack  = 1'b0;
    bus.reconfig_busy = 1'b0;
    rcfg_active       = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.reconfig_req && ack_en && !rst) begin
        for (int i = 1; i < ack_dly; i++) @(negedge clk);
        bus.reconfig_ack  = 1'b1;
        bus.reconfig_busy = 1'b1;
        rcfg_active       = 1'b1;
        @(negedge clk);
        bus.reconfig_ack = 1'b0;
        for (int i = 1; i < busy_len; i++) @(negedge clk);
        bus.reconfig_busy = 1'b0;
        @(negedge clk);
        rcfg_active = 1'b0;
      end
    end
  end

  // Counts rising edges of reconfig_req.
  int req_cnt = 0;
  logic req_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (bus.reconfig_req && !req_prev) req_cnt++;
    req_prev = bus.reconfig_req;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (bus.spd_chg_busy && n < limit) begin @(negedge clk); n++; end
    if (bus.spd_chg_busy) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: still busy after %0d cycles", tag, n);
    end
  endtask

  // Request one code and compare all status against the model.
  task automatic apply(input logic [3:0] code, input string tag);
    int c0, exp_req;
    c0 = req_cnt;
    exp_req = 0;
    bus.cfg_linkspeed = code;
    if (code != m_cur) begin
      if (code >= 4'h1 && code <= 4'h4) begin
        m_cur = code; m_stat = code; m_req_le = code; m_err = 1'b0; exp_req = 1;
      end else if (code >= 4'h5) begin
        m_err = 1'b1;
      end
    end
    wait_idle(tag, 3000);
    n_cmp++; if (bus.stat_LE_LINKSPEED !== m_stat) begin n_err++;
      $display("FAIL %s stat: got %0h want %0h", tag, bus.stat_LE_LINKSPEED, m_stat); end
    n_cmp++; if (bus.req_LE_LINKSPEED !== m_req_le) begin n_err++;
      $display("FAIL %s req_LE: got %0h want %0h", tag, bus.req_LE_LINKSPEED, m_req_le); end
    n_cmp++; if (bus.spd_chg_err !== m_err) begin n_err++;
      $display("FAIL %s err: got %0b want %0b", tag, bus.spd_chg_err, m_err); end
    n_cmp++; if (req_cnt - c0 != exp_req) begin n_err++;
      $display("FAIL %s req_count: got %0d want %0d", tag, req_cnt - c0, exp_req); end
    n_cmp++; if (bus.reconfig_req !== 1'b0) begin n_err++;
      $display("FAIL %s req_idle: got %0b want 0", tag, bus.reconfig_req); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_linkspeed = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.reconfig_req, bus.reconfig_speed, bus.req_LE_LINKSPEED,
                  bus.stat_LE_LINKSPEED, bus.spd_chg_busy, bus.spd_chg_err} !== 14'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {bus.reconfig_req,
        bus.reconfig_speed, bus.req_LE_LINKSPEED, bus.stat_LE_LINKSPEED,
        bus.spd_chg_busy, bus.spd_chg_err}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.spd_chg_busy !== 1'b0 || bus.reconfig_req !== 1'b0) begin n_err++;
      $display("FAIL reset_idle_cfg0: busy=%0b req=%0b want 0/0", bus.spd_chg_busy, bus.reconfig_req); end
  endtask

  task automatic test_basic();
    ack_en = 1'b1; lock_en = 1'b1; ack_dly = 3; busy_len = 10;
    bus.cfg_linkspeed = 4'h2;             // change after edge N
    @(negedge clk);                       // after N+1
    n_cmp++; if (bus.reconfig_req !== 1'b0) begin n_err++;
      $display("FAIL basic_early_req: got %0b want 0 at N+1", bus.reconfig_req); end
    @(negedge clk);                       // after N+2
    n_cmp++; if (bus.req_LE_LINKSPEED !== 4'h2) begin n_err++;
      $display("FAIL basic_req_le_n2: got %0h want 2", bus.req_LE_LINKSPEED); end
    n_cmp++; if (bus.reconfig_req !== 1'b1 || bus.spd_chg_busy !== 1'b1) begin n_err++;
      $display("FAIL basic_req_busy_n2: req=%0b busy=%0b want 1/1", bus.reconfig_req, bus.spd_chg_busy); end
    n_cmp++; if (bus.reconfig_speed !== 4'h2 || bus.stat_LE_LINKSPEED !== 4'h0) begin n_err++;
      $display("FAIL basic_speed_stat_n2: speed=%0h stat=%0h want 2/0", bus.reconfig_speed, bus.stat_LE_LINKSPEED); end
    wait_idle("basic", 500);
    m_cur = 4'h2; m_stat = 4'h2; m_req_le = 4'h2; m_err = 1'b0;
    n_cmp++; if (bus.stat_LE_LINKSPEED !== 4'h2 || bus.spd_chg_err !== 1'b0) begin n_err++;
      $display("FAIL basic_done: stat=%0h err=%0b want 2/0", bus.stat_LE_LINKSPEED, bus.spd_chg_err); end
  endtask

  task automatic test_toggle_mid();
    int c0, n;
    c0 = req_cnt;
    ack_dly = 2; busy_len = 8;
    bus.cfg_linkspeed = 4'h4;
    n = 0;
    while (!bus.reconfig_busy && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    bus.cfg_linkspeed = 4'h1;             // during WAIT_DONE
    n = 0;
    while (bus.stat_LE_LINKSPEED !== 4'h4 && n < 2000) begin @(negedge clk); n++; end
    n_cmp++; if (bus.stat_LE_LINKSPEED !== 4'h4) begin n_err++;
      $display("FAIL toggle_first: stat=%0h want 4", bus.stat_LE_LINKSPEED); end
    wait_idle("toggle", 2000);
    m_cur = 4'h1; m_stat = 4'h1; m_req_le = 4'h1; m_err = 1'b0;
    n_cmp++; if (bus.stat_LE_LINKSPEED !== 4'h1 || bus.req_LE_LINKSPEED !== 4'h1) begin n_err++;
      $display("FAIL toggle_second: stat=%0h req_LE=%0h want 1/1", bus.stat_LE_LINKSPEED, bus.req_LE_LINKSPEED); end
    n_cmp++; if (req_cnt - c0 != 2) begin n_err++;
      $display("FAIL toggle_req_count: got %0d want 2", req_cnt - c0); end
  endtask

  task automatic test_random();
    logic [3:0] code;
    for (int it = 0; it < 14; it++) begin
      ack_dly  = $urandom_range(1, 5);
      busy_len = $urandom_range(2, 12);
      if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(5, 15));
      else code = 4'($urandom_range(0, 4));
      apply(code, "random");
    end
  endtask

  task automatic test_lock_fail();
    int c0;
    c0 = req_cnt;
    ack_en = 1'b1; lock_en = 1'b0; ack_dly = 2; busy_len = 4;
    bus.cfg_linkspeed = (m_cur == 4'h3) ? 4'h2 : 4'h3;
    repeat (4) @(negedge clk);
    bus.cfg_linkspeed = 4'h0;             // keep IDLE quiet after failure
    wait_idle("lock_fail", 5000);
    n_cmp++; if (req_cnt - c0 != EXP_ATTEMPTS) begin n_err++;
      $display("FAIL lock_fail_attempts: got %0d want %0d", req_cnt - c0, EXP_ATTEMPTS); end
    n_cmp++; if (bus.spd_chg_err !== 1'b1 || bus.stat_LE_LINKSPEED !== 4'h0) begin n_err++;
      $display("FAIL lock_fail_flags: err=%0b stat=%0h want 1/0", bus.spd_chg_err, bus.stat_LE_LINKSPEED); end
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.spd_chg_busy !== 1'b0 || bus.spd_chg_err !== 1'b1) begin n_err++;
      $display("FAIL lock_fail_hold: busy=%0b err=%0b want 0/1", bus.spd_chg_busy, bus.spd_chg_err); end
    m_cur = 4'h0; m_stat = 4'h0; m_err = 1'b1;
  endtask

  task automatic test_no_ack();
    int n;
    ack_en = 1'b0; lock_en = 1'b1;
    bus.cfg_linkspeed = 4'h2;
    n = 0;
    while (!bus.reconfig_req && n < 10) begin @(negedge clk); n++; end
    bus.cfg_linkspeed = 4'h0;
    n = 0;
    while (bus.reconfig_req && n < 1000) begin n++; @(negedge clk); end
    n_cmp++; if (n != 256) begin n_err++;
      $display("FAIL no_ack_timeout_cycles: got %0d want 256", n); end
    n_cmp++; if (bus.spd_chg_err !== 1'b1 || bus.reconfig_req !== 1'b0 || bus.spd_chg_busy !== 1'b0) begin n_err++;
      $display("FAIL no_ack_flags: err=%0b req=%0b busy=%0b want 1/0/0",
               bus.spd_chg_err, bus.reconfig_req, bus.spd_chg_busy); end
    m_cur = 4'h0; m_stat = 4'h0; m_req_le = 4'h2; m_err = 1'b1;
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    lock_en = 1'b0; ack_dly = 2; busy_len = 3;
    bus.cfg_linkspeed = 4'h2;
    n = 0;
    while (!bus.reconfig_busy && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (bus.reconfig_busy && n < 50) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);            // now in WAIT_LOCK
    n_cmp++; if (bus.spd_chg_busy !== 1'b1) begin n_err++;
      $display("FAIL rst_mid_inflight: busy=%0b want 1", bus.spd_chg_busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.reconfig_req, bus.reconfig_speed, bus.req_LE_LINKSPEED,
                  bus.stat_LE_LINKSPEED, bus.spd_chg_busy, bus.spd_chg_err} !== 14'h0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %h want 0", {bus.reconfig_req,
        bus.reconfig_speed, bus.req_LE_LINKSPEED, bus.stat_LE_LINKSPEED,
        bus.spd_chg_busy, bus.spd_chg_err}); end
    @(negedge clk);
    rst = 1'b0; lock_en = 1'b1;
    m_cur = 4'h0; m_stat = 4'h0; m_req_le = 4'h0; m_err = 1'b0;
    apply(4'h2, "rst_restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_mid();
    apply(4'h7, "illegal");
    test_random();
    test_lock_fail();
    test_no_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spd_req_ctrl.md
# spd_req_ctrl

Initiating side of the link-speed change protocol. The block accepts a host-requested link speed and sequences the transceiver reconfiguration controller through a request/acknowledge/busy handshake. It waits for RX CDR lock at the new rate, retrying on lock timeout, and then publishes `req_LE_LINKSPEED` and `stat_LE_LINKSPEED` to the link-monitor masking logic downstream.

## Interface
Parameters:
- `TMO_W`, default 24: timeout counter width; every timeout fires after 2^TMO_W cycles in a state.
- `MAX_RETRY`, default 3: number of reconfiguration retries after a lock timeout. Used only with `SPD_REQ_RETRY_EN`.
- `SIM_ONLY`, default 0: when 1, the effective timeout is 2^8 cycles instead of 2^TMO_W.

Ports:
- `clk` in 1: single clock, used by all logic.
- `rst` in 1: reset, asynchronous and active-high.
- `cfg_linkspeed` in 4: requested speed, quasi-static host register. 4'h0 means no request. Legal codes are 4'h1..4'h4.
- `reconfig_req` out 1: reconfiguration request, held until acknowledged.
- `reconfig_speed` out 4: target speed, stable while `reconfig_req` is high.
- `reconfig_ack` in 1: single-cycle acknowledge from the reconfiguration controller (`clk` domain).
- `reconfig_busy` in 1: reconfiguration in progress (`clk` domain).
- `rx_is_lockedtodata` in 1: CDR lock. Asynchronous; synchronized internally with 2 flops.
- `req_LE_LINKSPEED` out 4: speed currently being applied or already applied.
- `stat_LE_LINKSPEED` out 4: speed achieved. 4'h0 while a change is in flight or after a failure.
- `spd_chg_busy` out 1: high in every state except IDLE.
- `spd_chg_err` out 1: sticky error flag.

## Operation
- `cfg_linkspeed` is registered to `cfg_q` (1 cycle). The block holds `cur_spd`, the last successfully applied speed (reset 0).
- State machine states: IDLE, REQ, WAIT_DONE, WAIT_LOCK, RETRY.
- IDLE transitions:
  - If `cfg_q` is legal and `cfg_q != cur_spd`: latch `tgt = cfg_q`, set the retry count to 0, clear `spd_chg_err`, go to REQ.
  - If `cfg_q` is in 4'h5..4'hF and `cfg_q != cur_spd`: set `spd_chg_err` and stay in IDLE. No change is attempted.
  - If `cfg_q` is 4'h0: no action.
- REQ:
  - Outputs: `reconfig_req=1`, `reconfig_speed=tgt`, `req_LE_LINKSPEED=tgt`, `stat_LE_LINKSPEED=0`.
  - When `reconfig_ack` is seen: drop `reconfig_req`, go to WAIT_DONE.
  - On timeout: set err, set `cur_spd=0`, go to IDLE.
- WAIT_DONE: when `reconfig_busy` is 0 (sampled on any cycle after entry), go to WAIT_LOCK. On timeout: same handling as REQ.
- WAIT_LOCK:
  - When synchronized lock is 1: set `cur_spd=tgt`, `stat_LE_LINKSPEED=tgt`, go to IDLE.
  - On timeout: go to RETRY.
- RETRY (one cycle):
  - If the retry count is below `MAX_RETRY`: increment it, go to REQ.
  - Otherwise: set err, set `cur_spd=0`, `stat=0`, go to IDLE.
- Timeout counter:
  - Cleared on every state entry; increments in REQ, WAIT_DONE and WAIT_LOCK.
  - Timeout condition is the counter reaching all-ones. The counter saturates and never wraps.
- `cfg_linkspeed` changes while the block is busy are ignored until IDLE. They are then seen as a new request, because `cfg_q != cur_spd`.
- A failed target leaves `cur_spd=0`. If `cfg_q` is unchanged, IDLE retries the same target on the next cycle. `spd_chg_err` is cleared at that new attempt.
- Lock loss after success causes no action; the downstream monitor masks it.

## Timing
- Reset values: `reconfig_req` 0, `reconfig_speed` 0, `req_LE_LINKSPEED` 0, `stat_LE_LINKSPEED` 0, `spd_chg_busy` 0, `spd_chg_err` 0. State is IDLE, `cur_spd` 0.
- All outputs are registered.
- From a `cfg_linkspeed` change at edge N:
  - `cfg_q` updates at edge N+1.
  - REQ is entered at edge N+2; `reconfig_req`, `spd_chg_busy`, the new `req_LE_LINKSPEED` and `stat=0` are all visible after edge N+2.
- When `reconfig_ack` is high at edge M, `reconfig_req` is low after edge M.
- Lock path: the synchronizer adds 2 cycles. `stat_LE_LINKSPEED` updates 1 cycle after the synchronized lock is sampled high in WAIT_LOCK.
- Asserting `rst` in any state immediately forces the reset values above.

## Configuration
- `SPD_REQ_RETRY_EN` defined: the RETRY state is used and `MAX_RETRY` applies.
- `SPD_REQ_RETRY_EN` undefined: a WAIT_LOCK timeout goes directly to the failure path (set err, `cur_spd=0`, `stat=0`, go to IDLE). The retry counter is not synthesized.

## Test plan
- After reset, set `cfg_linkspeed`=4'h2. Ack after 3 cycles, busy for 10 cycles, then lock. Required: `req_LE_LINKSPEED`=2 at edge N+2, `stat`=2, `spd_chg_busy`=0, `spd_chg_err`=0.
- From speed 2, set `cfg`=4'h4 and toggle `cfg` to 4'h1 mid-WAIT_DONE. Required: `stat` reaches 4, then a second sequence runs and ends with `stat`=1.
- `cfg`=4'h7. Required: `spd_chg_err`=1, `reconfig_req` never asserts, `req_LE_LINKSPEED` is unchanged.
- `SIM_ONLY=1` with lock held low:
  - With the macro and `MAX_RETRY`=3: 4 `reconfig_req` assertions, then `spd_chg_err`=1 and `stat`=0.
  - Without the macro: exactly 1 assertion, then the same final flags.
- No `reconfig_ack`. Required: timeout after 256 cycles (`SIM_ONLY`), `spd_chg_err`=1, `reconfig_req`=0.
- Assert `rst` during WAIT_LOCK. Required: all outputs return to 0 the same cycle. After release with `cfg`=2, a full sequence restarts.
